// File: rtl/register_file_mp_if.sv
// rtl/register_file_mp_if.sv - Bus interface for the multi-port register file
//
// Groups the read, write, issue and scoreboard signals of register_file_mp.
//   master : decode/writeback side, drives addresses, write data and issue
//   slave  : register file, returns read data, read-busy flags and busy_vec
// Packed vectors carry one lane per port: port p at [p*W +: W].
interface register_file_mp_if #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1
);
    localparam int AW = $clog2(REG_COUNT);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [REG_COUNT-1:0]   busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rdata, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rdata, rd_busy, busy_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - Multi-port register file with bypass and busy scoreboard
//
// Ports:
//   clk     rising-edge clock
//   areset  asynchronous active-high reset; clears registers and scoreboard
//   bus     register_file_mp_if.slave
//           rd_addr/rdata/rd_busy : NUM_RD combinational read ports
//           wr_en/wr_addr/wr_data : NUM_WR write ports, committed at clk edge
//           iss_en/iss_addr       : marks a destination register busy
//           busy_vec              : registered per-register busy flags
module register_file_mp #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic              clk,
    input  logic              areset,
    register_file_mp_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);

    logic [XLEN-1:0]            regs_q [REG_COUNT];
    logic [XLEN-1:0]            regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]       busy_q;
    logic [REG_COUNT-1:0]       busy_d;
    logic [REG_COUNT-1:0]       set_v;
    logic [REG_COUNT-1:0]       clr_v;
    logic [NUM_WR-1:0]          wr_ok;
    logic [NUM_RD-1:0][AW-1:0]  ra_v;
    logic [NUM_RD-1:0]          hit_v;
    logic [NUM_RD*XLEN-1:0]     rdata_c;
    logic [NUM_RD-1:0]          rd_busy_c;

    // A write is effective unless it targets the hardwired zero register.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = bus.wr_en[w] &&
                       !((ZERO_REG != 0) && (bus.wr_addr[w*AW +: AW] == '0));
        end
    end

    // Ascending port order: the highest-indexed writer to an address wins.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                regs_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard: issue sets, any write clears, issue wins when both hit.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (bus.iss_en) begin
            set_v[bus.iss_addr] = 1'b1;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w]) begin
                clr_v[bus.wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
        busy_d = set_v | (busy_q & ~clr_v);
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Reads: stored value, overridden by a same-cycle write when bypassing.
    // A forwarded result also hides the busy flag, since the data is here now.
    always_comb begin
        ra_v      = '0;
        hit_v     = '0;
        rdata_c   = '0;
        rd_busy_c = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra_v[p] = bus.rd_addr[p*AW +: AW];
            rdata_c[p*XLEN +: XLEN] = regs_q[ra_v[p]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (bus.wr_addr[w*AW +: AW] == ra_v[p])) begin
                        rdata_c[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
                        hit_v[p] = 1'b1;
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra_v[p] == '0)) begin
                rdata_c[p*XLEN +: XLEN] = '0;
            end
            // Stored values are already cleared in reset; this also blocks bypass.
            if (areset) begin
                rdata_c[p*XLEN +: XLEN] = '0;
            end
            rd_busy_c[p] = busy_q[ra_v[p]] & ~hit_v[p];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - Self-checking bench for register_file_mp
module tb_register_file_mp;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  we = '0;
    logic [9:0]  wa = '0;
    logic [63:0] wd = '0;
    logic        ie = 1'b0;
    logic [4:0]  ia = '0;
    logic [9:0]  ra = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [32];
    logic [31:0] mb;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        rb_a;
        logic        rb_b;
        logic [31:0] busy;
    } vec_t;
    vec_t vecs [11];

    register_file_mp_if #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    register_file_mp_if #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2)) bus_b ();

    assign bus_a.rd_addr = ra;  assign bus_b.rd_addr = ra;
    assign bus_a.wr_en   = we;  assign bus_b.wr_en   = we;
    assign bus_a.wr_addr = wa;  assign bus_b.wr_addr = wa;
    assign bus_a.wr_data = wd;  assign bus_b.wr_data = wd;
    assign bus_a.iss_en  = ie;  assign bus_b.iss_en  = ie;
    assign bus_a.iss_addr = ia; assign bus_b.iss_addr = ia;

    register_file_mp #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .areset(areset), .bus(bus_a.slave));
    register_file_mp #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .areset(areset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mem[r] = '0;
        mb = '0;
    endtask

    // Reference: what a reader at address a should see this cycle.
    task automatic model_read(input bit bp, input logic [4:0] a,
                              output logic [31:0] v, output logic rb);
        bit fwd;
        fwd = 0;
        v = mem[a];
        if (bp && a != 0) begin
            for (int w = 0; w < 2; w++) begin
                if (we[w] && wa[w*5 +: 5] == a) begin
                    v = wd[w*32 +: 32];
                    fwd = 1;
                end
            end
        end
        if (a == 0) v = '0;
        rb = mb[a] && !fwd;
    endtask

    // Reference: state after the clock edge.
    task automatic model_update();
        logic [31:0] nb;
        nb = mb;
        for (int w = 0; w < 2; w++) begin
            if (we[w] && wa[w*5 +: 5] != 0) mem[wa[w*5 +: 5]] = wd[w*32 +: 32];
            if (we[w]) nb[wa[w*5 +: 5]] = 1'b0;
        end
        if (ie) nb[ia] = 1'b1;
        nb[0] = 1'b0;
        mb = nb;
    endtask

    task automatic check_model(input int cyc);
        logic [31:0] v;
        logic        rb;
        for (int p = 0; p < 2; p++) begin
            model_read(1'b1, ra[p*5 +: 5], v, rb);
            chk($sformatf("rnd%0d byp rdata%0d", cyc, p), bus_a.rdata[p*32 +: 32], v);
            chk($sformatf("rnd%0d byp rd_busy%0d", cyc, p), {31'd0, bus_a.rd_busy[p]}, {31'd0, rb});
            model_read(1'b0, ra[p*5 +: 5], v, rb);
            chk($sformatf("rnd%0d nobyp rdata%0d", cyc, p), bus_b.rdata[p*32 +: 32], v);
            chk($sformatf("rnd%0d nobyp rd_busy%0d", cyc, p), {31'd0, bus_b.rd_busy[p]}, {31'd0, rb});
        end
        chk($sformatf("rnd%0d busy_vec_a", cyc), bus_a.busy_vec, mb);
        chk($sformatf("rnd%0d busy_vec_b", cyc), bus_b.busy_vec, mb);
    endtask

    initial begin
        //          we     wa0   wd0           wa1   wd1    ie    ia    ra    exp_a         exp_b         rba   rbb   busy
        vecs[0]  = '{2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0};
        vecs[1]  = '{2'b01, 5'd3, 32'h11,        5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0};
        vecs[2]  = '{2'b01, 5'd3, 32'h22,        5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h22, 32'h11, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h22, 32'h22, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{2'b11, 5'd7, 32'hA,         5'd7, 32'hB, 1'b0, 5'd0, 5'd7, 32'hB,  32'h0,  1'b0, 1'b0, 32'h0};
        vecs[5]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 32'hB,  32'hB,  1'b0, 1'b0, 32'h0};
        vecs[6]  = '{2'b01, 5'd9, 32'h99,        5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 32'h99, 32'h0,  1'b0, 1'b1, 32'h200};
        vecs[7]  = '{2'b01, 5'd9, 32'h55,        5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h55, 32'h99, 1'b0, 1'b1, 32'h200};
        vecs[8]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b1, 5'd4, 5'd9, 32'h55, 32'h55, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{2'b10, 5'd0, 32'h0,         5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 32'h44, 32'h0,  1'b0, 1'b1, 32'h10};
        vecs[10] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 32'h44, 32'h44, 1'b0, 1'b0, 32'h0};

        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("reset busy_vec", bus_a.busy_vec, 32'h0);
        chk("reset rdata", bus_a.rdata[31:0], 32'h0);

        // Asynchronous reset in mid-cycle, with a write pending.
        @(negedge clk);
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEAD}; ie = 1'b1; ia = 5'd12; ra = {5'd0, 5'd5};
        @(posedge clk);
        @(negedge clk);
        we = 2'b00; ie = 1'b0;
        #1;
        chk("pre-reset x5", bus_a.rdata[31:0], 32'hDEAD);
        chk("pre-reset busy", bus_a.busy_vec, 32'h1000);
        #1;
        we = 2'b01; wd = {32'h0, 32'h1234}; areset = 1'b1;
        #1;
        chk("async reset rdata byp", bus_a.rdata[31:0], 32'h0);
        chk("async reset rdata nobyp", bus_b.rdata[31:0], 32'h0);
        chk("async reset busy", bus_a.busy_vec, 32'h0);
        @(posedge clk);
        #1;
        chk("held reset rdata", bus_a.rdata[31:0], 32'h0);
        chk("held reset busy", bus_b.busy_vec, 32'h0);
        @(negedge clk);
        areset = 1'b0; we = 2'b00;
        #1;
        chk("post-reset x5 dropped", bus_b.rdata[31:0], 32'h0);
        model_clear();

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            wa = {vecs[i].wa1, vecs[i].wa0};
            wd = {vecs[i].wd1, vecs[i].wd0};
            ie = vecs[i].ie; ia = vecs[i].ia;
            ra = {5'd0, vecs[i].ra};
            #1;
            chk($sformatf("vec%0d rdata byp", i), bus_a.rdata[31:0], vecs[i].exp_a);
            chk($sformatf("vec%0d rdata nobyp", i), bus_b.rdata[31:0], vecs[i].exp_b);
            chk($sformatf("vec%0d rd_busy byp", i), {31'd0, bus_a.rd_busy[0]}, {31'd0, vecs[i].rb_a});
            chk($sformatf("vec%0d rd_busy nobyp", i), {31'd0, bus_b.rd_busy[0]}, {31'd0, vecs[i].rb_b});
            chk($sformatf("vec%0d busy_vec", i), bus_a.busy_vec, vecs[i].busy);
            @(posedge clk);
            model_update();
        end

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we = 2'($urandom_range(0, 3));
            wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wd = {$urandom, $urandom};
            ie = 1'($urandom_range(0, 1));
            ia = 5'($urandom_range(0, 7));
            ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            check_model(c);
            @(posedge clk);
            model_update();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
